// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared FSM encodings, display codes and the BCD increment helper for the stopwatch.
package stopwatch_bcd_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_DASH  = 4'hA;
  localparam logic [3:0]  BCD_BLANK = 4'hB;
  localparam logic [15:0] X_DASHES  = {4{BCD_DASH}};

  // Returns {carry_out, next_digits}; the carry ripples through all four digits at once.
  function automatic logic [16:0] bcd_inc4(input logic [15:0] d);
    logic [16:0] r;
    logic        c;
    r = '0;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c && d[i*4 +: 4] == 4'd9) begin
        r[i*4 +: 4] = 4'd0;
      end else if (c) begin
        r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        r[i*4 +: 4] = d[i*4 +: 4];
      end
    end
    r[16] = c;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Button inputs and display/status outputs of the stopwatch, grouped as one port.
interface stopwatch_bcd_counter_if;
  logic        btn_ss;
  logic        btn_clr;
  logic [15:0] x;
  logic        running;
  logic        ovf;

  modport master (output btn_ss, output btn_clr, input x, input running, input ovf);
  modport slave  (input btn_ss, input btn_clr, output x, output running, output ovf);
endinterface

// File: rtl/stopwatch_bcd_counter_btn_debounce.sv
// Raw pushbutton -> 2-FF synchroniser -> stability counter -> one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Any return of the synced level to the accepted level restarts the count.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        pulse <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Centisecond stopwatch: debounced start/stop and clear, IDLE/RUN/PAUSE FSM,
// prescaled 00.00..99.99 BCD cascade and registered display word.
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    clr_n,
  stopwatch_bcd_counter_if.slave  sw
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic          ss_p;
  logic          clr_p;
  state_t        state;
  logic [PW-1:0] pre;
  logic [15:0]   digits;
  logic [15:0]   x_q;
  logic          running_q;
  logic          ovf_q;
  logic          tick;
  logic [16:0]   inc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (sw.btn_ss),
    .pulse (ss_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (sw.btn_clr),
    .pulse (clr_p)
  );

  always_comb tick = (pre == PW'(DIV - 1));
  always_comb inc  = bcd_inc4(digits);

  // x is loaded at the same edge as the digits, so it never lags the counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      pre       <= '0;
      digits    <= '0;
      x_q       <= X_DASHES;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          pre    <= '0;
          digits <= '0;
          ovf_q  <= 1'b0;
          if (ss_p) begin
            state     <= S_RUN;
            x_q       <= '0;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick) begin
            pre    <= '0;
            digits <= inc[15:0];
            x_q    <= inc[15:0];
            if (inc[16]) ovf_q <= 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
          if (ss_p) begin
            state     <= S_PAUSE;
            running_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (clr_p) begin
            state  <= S_IDLE;
            pre    <= '0;
            digits <= '0;
            ovf_q  <= 1'b0;
            x_q    <= X_DASHES;
          end else if (ss_p) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          x_q       <= X_DASHES;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw.x       = x_q;
  assign sw.running = running_q;
  assign sw.ovf     = ovf_q;

endmodule
